// File: rtl/assert_ctl_pkg.sv
// rtl/assert_ctl_pkg.sv - shared types and default parameters for the assertion-control driver
package assert_ctl_pkg;

  // Command opcodes carried on cmd_op
  typedef enum logic [1:0] {
    OP_ON      = 2'd0,
    OP_OFF     = 2'd1,
    OP_KILL    = 2'd2,
    OP_OFF_FOR = 2'd3
  } assert_ctl_op_e;

  // Driver FSM states
  typedef enum logic [1:0] {
    ST_HOLDOFF = 2'd0,
    ST_IDLE    = 2'd1,
    ST_WINDOW  = 2'd2
  } assert_ctl_state_e;

  localparam int DEF_NGRP    = 4;
  localparam int DEF_HOLDOFF = 16;
  localparam int DEF_CNT_W   = 8;

  // Counter width able to hold both a window length and HOLDOFF-1
  function automatic int cnt_width(input int cnt_w, input int holdoff);
    int hw;
    hw = (holdoff > 1) ? $clog2(holdoff) : 1;
    return (cnt_w > hw) ? cnt_w : hw;
  endfunction

endpackage

// File: rtl/assert_ctl_driver_if.sv
// rtl/assert_ctl_driver_if.sv - command port and control outputs of the assertion-control driver
interface assert_ctl_driver_if
  import assert_ctl_pkg::*;
#(
  parameter int NGRP  = DEF_NGRP,
  parameter int CNT_W = DEF_CNT_W
);

  logic             cmd_valid;
  logic             cmd_ready;
  assert_ctl_op_e   cmd_op;
  logic [NGRP-1:0]  cmd_mask;
  logic [CNT_W-1:0] cmd_len;
  logic [NGRP-1:0]  assert_en;
  logic [NGRP-1:0]  assert_kill;
  logic             busy;

  // Command source and consumer of the enable/kill controls
  modport master (
    output cmd_valid, cmd_op, cmd_mask, cmd_len,
    input  cmd_ready, assert_en, assert_kill, busy
  );

  // The driver itself
  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, cmd_len,
    output cmd_ready, assert_en, assert_kill, busy
  );

endinterface

// File: rtl/assert_ctl_wincnt.sv
// rtl/assert_ctl_wincnt.sv - loadable down-counter shared by the holdoff and timed-off windows
module assert_ctl_wincnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         busy_o,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over decrement; the count parks at zero once exhausted
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register, cleared by reset so the holdoff always starts from scratch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/assert_ctl_driver.sv
// rtl/assert_ctl_driver.sv - command-driven per-group assertion enable/kill generator (optional ASSERT_CTL_KILL_EN)
module assert_ctl_driver
  import assert_ctl_pkg::*;
#(
  parameter int NGRP    = DEF_NGRP,
  parameter int HOLDOFF = DEF_HOLDOFF,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic          clk,
  input logic          rst_n,
  assert_ctl_driver_if.slave ctl
);

  localparam int CW = cnt_width(CNT_W, HOLDOFF);

  assert_ctl_state_e state_q, state_d;
  logic [NGRP-1:0]   en_q, en_d;
  logic [NGRP-1:0]   mask_q, mask_d;
  logic              cnt_load;
  logic [CW-1:0]     cnt_val;
  logic              cnt_busy;
  logic              cnt_done;
`ifdef ASSERT_CTL_KILL_EN
  logic [NGRP-1:0]   kill_q, kill_d;
`endif

  // One counter serves both phases: they never overlap, and it is idle (zero) in IDLE
  assert_ctl_wincnt #(
    .W (CW)
  ) u_wincnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .busy_o     (cnt_busy),
    .done_o     (cnt_done)
  );

  // Next-state, enable update and counter control
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mask_d   = mask_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
`ifdef ASSERT_CTL_KILL_EN
    kill_d   = '0;
`endif
    case (state_q)
      ST_HOLDOFF: begin
        // First posedge after release arms the counter with HOLDOFF-1 so the
        // exit lands on the HOLDOFF-th posedge; 0 or 1 exits immediately.
        if (!cnt_busy) begin
          if (HOLDOFF <= 1) begin
            state_d = ST_IDLE;
            en_d    = '1;
          end else begin
            cnt_load = 1'b1;
            cnt_val  = CW'(HOLDOFF - 1);
          end
        end else if (cnt_done) begin
          state_d = ST_IDLE;
          en_d    = '1;
        end
      end
      ST_IDLE: begin
        if (ctl.cmd_valid) begin
          case (ctl.cmd_op)
            OP_ON:  en_d = en_q | ctl.cmd_mask;
            OP_OFF: en_d = en_q & ~ctl.cmd_mask;
            OP_KILL: begin
`ifdef ASSERT_CTL_KILL_EN
              kill_d = ctl.cmd_mask;
`else
              en_d   = en_q & ~ctl.cmd_mask;
`endif
            end
            OP_OFF_FOR: begin
              en_d     = en_q & ~ctl.cmd_mask;
              mask_d   = ctl.cmd_mask;
              cnt_load = 1'b1;
              cnt_val  = (ctl.cmd_len == '0) ? CW'(1) : CW'(ctl.cmd_len);
              state_d  = ST_WINDOW;
            end
            default: en_d = en_q;
          endcase
        end
      end
      ST_WINDOW: begin
        // Only the saved groups are restored; others keep whatever they hold
        if (cnt_done) begin
          en_d    = en_q | mask_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_HOLDOFF;
      end
    endcase
  end

  // State, enable and saved-mask registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HOLDOFF;
      en_q    <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      mask_q  <= mask_d;
    end
  end

`ifdef ASSERT_CTL_KILL_EN
  // Kill pulse register; kill_d defaults to zero so each pulse lasts one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_q <= '0;
    end else begin
      kill_q <= kill_d;
    end
  end

  assign ctl.assert_kill = kill_q;
`else
  assign ctl.assert_kill = '0;
`endif

  assign ctl.assert_en = en_q;
  assign ctl.cmd_ready = (state_q == ST_IDLE);
  assign ctl.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_assert_ctl_driver.sv
// tb/tb_assert_ctl_driver.sv - directed self-checking bench for assert_ctl_driver
module tb_assert_ctl_driver;
  import assert_ctl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  assert_ctl_driver_if #(.NGRP(4), .CNT_W(8)) bus ();

  assert_ctl_driver #(
    .NGRP    (4),
    .HOLDOFF (16),
    .CNT_W   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] en, input logic [3:0] kill,
                           input logic ready, input logic busy);
    chk({tag, ".en"},    32'(bus.assert_en),   32'(en));
    chk({tag, ".kill"},  32'(bus.assert_kill), 32'(kill));
    chk({tag, ".ready"}, 32'(bus.cmd_ready),   32'(ready));
    chk({tag, ".busy"},  32'(bus.busy),        32'(busy));
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cmd(input assert_ctl_op_e op, input logic [3:0] mask, input logic [7:0] len);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_mask  = mask;
    bus.cmd_len   = len;
  endtask

  task automatic clr_cmd;
    bus.cmd_valid = 1'b0;
    bus.cmd_mask  = 4'h0;
    bus.cmd_len   = 8'h0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_ON;
    bus.cmd_mask  = 4'h0;
    bus.cmd_len   = 8'h0;

    repeat (2) @(negedge clk);
    check_out("reset", 4'h0, 4'h0, 1'b0, 1'b1);

    // Holdoff: 15 posedges still disabled, all-ones after the 16th
    rst_n = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick;
      check_out($sformatf("holdoff%0d", i), 4'h0, 4'h0, 1'b0, 1'b1);
    end
    tick;
    check_out("holdoff_done", 4'hF, 4'h0, 1'b1, 1'b0);

    // OFF then ON
    set_cmd(OP_OFF, 4'b0101, 8'd0); tick; clr_cmd;
    check_out("off", 4'b1010, 4'h0, 1'b1, 1'b0);
    set_cmd(OP_ON, 4'b0001, 8'd0); tick; clr_cmd;
    check_out("on", 4'b1011, 4'h0, 1'b1, 1'b0);
    set_cmd(OP_ON, 4'b1111, 8'd0); tick; clr_cmd;
    check_out("on_all", 4'hF, 4'h0, 1'b1, 1'b0);

    // KILL
    set_cmd(OP_KILL, 4'b0110, 8'd0); tick; clr_cmd;
`ifdef ASSERT_CTL_KILL_EN
    check_out("kill", 4'hF, 4'b0110, 1'b1, 1'b0);
    tick;
    check_out("kill_end", 4'hF, 4'h0, 1'b1, 1'b0);
`else
    check_out("kill_as_off", 4'b1001, 4'h0, 1'b1, 1'b0);
    set_cmd(OP_ON, 4'b1111, 8'd0); tick; clr_cmd;
    check_out("kill_restore", 4'hF, 4'h0, 1'b1, 1'b0);
`endif

    // OFF_FOR len 5 with a second OFF_FOR held valid through the window
    set_cmd(OP_OFF_FOR, 4'b1000, 8'd5); tick;
    set_cmd(OP_OFF_FOR, 4'b0001, 8'd2);
    check_out("win1", 4'b0111, 4'h0, 1'b0, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      tick;
      check_out($sformatf("win%0d", i), 4'b0111, 4'h0, 1'b0, 1'b1);
    end
    tick;
    check_out("win_end", 4'hF, 4'h0, 1'b1, 1'b0);
    tick; clr_cmd;
    check_out("win2_1", 4'b1110, 4'h0, 1'b0, 1'b1);
    tick;
    check_out("win2_2", 4'b1110, 4'h0, 1'b0, 1'b1);
    tick;
    check_out("win2_end", 4'hF, 4'h0, 1'b1, 1'b0);

    // OFF_FOR len 0 behaves as a one-cycle window
    set_cmd(OP_OFF_FOR, 4'b0100, 8'd0); tick; clr_cmd;
    check_out("len0", 4'b1011, 4'h0, 1'b0, 1'b1);
    tick;
    check_out("len0_end", 4'hF, 4'h0, 1'b1, 1'b0);

    // OFF_FOR with empty mask still occupies the window
    set_cmd(OP_OFF_FOR, 4'b0000, 8'd3); tick; clr_cmd;
    check_out("mask0_1", 4'hF, 4'h0, 1'b0, 1'b1);
    tick;
    check_out("mask0_2", 4'hF, 4'h0, 1'b0, 1'b1);
    tick;
    check_out("mask0_3", 4'hF, 4'h0, 1'b0, 1'b1);
    tick;
    check_out("mask0_end", 4'hF, 4'h0, 1'b1, 1'b0);

    // Reset in the third window cycle, command held valid across reset and holdoff
    set_cmd(OP_OFF_FOR, 4'b0010, 8'd8); tick; clr_cmd;
    check_out("rwin1", 4'b1101, 4'h0, 1'b0, 1'b1);
    tick;
    check_out("rwin2", 4'b1101, 4'h0, 1'b0, 1'b1);
    tick;
    check_out("rwin3", 4'b1101, 4'h0, 1'b0, 1'b1);
    set_cmd(OP_OFF, 4'b0001, 8'd0);
    rst_n = 1'b0;
    #1;
    check_out("midrst", 4'h0, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick;
      check_out($sformatf("reholdoff%0d", i), 4'h0, 4'h0, 1'b0, 1'b1);
    end
    tick;
    check_out("reholdoff_done", 4'hF, 4'h0, 1'b1, 1'b0);
    tick; clr_cmd;
    check_out("post_reset_cmd", 4'b1110, 4'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
